mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mypack.sv | 29 ++
 rtl/mem_array.sv | 37 +++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mypack.sv
// rtl/mypack.sv - shared state types, word geometry and address-fault helper
package mypack;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int BE_W   = WORD_W / BYTE_W;

    // Memory responder handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mr_state_t;

    // Control unit sequencing states
    typedef enum logic [2:0] {
        UC_FETCH  = 3'd0,
        UC_DECODE = 3'd1,
        UC_EXEC   = 3'd2,
        UC_MEM    = 3'd3,
        UC_WB     = 3'd4
    } uc_state_t;

    // Misaligned or beyond the last word: the index is range-checked, never wrapped
    function automatic logic addr_fault(input logic [31:0] a, input int unsigned depth);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH x 32 word store, synchronous read, byte-enabled synchronous write
module mem_array
    import mypack::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WORD_W-1:0]        i_wdata,
    input  logic [BE_W-1:0]          i_be,
    output logic [WORD_W-1:0]        o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Byte-lane writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_addr][BYTE_W*i +: BYTE_W] <= i_wdata[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Registered read port, only updated when a load is issued
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request/ready memory slave with fixed wait states and fault reporting
module mem_responder
    import mypack::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int        AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mr_state_t   r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_fault;

    logic        w_accept;
    logic        w_go_resp;
    logic        w_a_we;
    logic [31:0] w_a_addr;
    logic [31:0] w_a_wdata;
    logic [3:0]  w_a_be;
    logic        w_fault;
    logic        w_mem_we;
    logic        w_mem_re;
    logic [31:0] w_mem_rdata;

    assign w_accept  = (r_state == IDLE) && req;
    // With no wait states the access completes straight from IDLE, so the
    // memory must see the live inputs on that edge rather than the latches.
    assign w_go_resp = (WAIT_CYCLES == 0) ? w_accept
                                          : ((r_state == WAIT) && (r_cnt == 4'd0));

    assign w_a_we    = (r_state == IDLE) ? we    : r_we;
    assign w_a_addr  = (r_state == IDLE) ? addr  : r_addr;
    assign w_a_wdata = (r_state == IDLE) ? wdata : r_wdata;
    assign w_a_be    = (r_state == IDLE) ? be    : r_be;

    assign w_fault   = addr_fault(w_a_addr, DEPTH);
    assign w_mem_we  = w_go_resp &&  w_a_we && !w_fault;
    assign w_mem_re  = w_go_resp && !w_a_we && !w_fault;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_a_addr[AW+1:2]),
        .i_wdata (w_a_wdata),
        .i_be    (w_a_be),
        .o_rdata (w_mem_rdata)
    );

    // Handshake sequencer: latch on accept, count wait states, one-cycle response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_fault <= 1'b0;
        end else begin
            if (w_go_resp) begin
                r_fault <= w_fault;
            end
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_be    <= be;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == RESP);
    assign err   = ready && r_fault;
    assign rdata = (ready && !r_we && !r_fault) ? w_mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed scoreboard bench for mem_responder (2 and 0 wait states)
module tb_mem_responder;

    typedef struct packed {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req2, we2;
    logic [31:0] addr2, wdata2;
    logic [3:0]  be2;
    logic [31:0] rdata2;
    logic        ready2, err2;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic [31:0] rdata0;
    logic        ready0, err0;

    int vectors     = 0;
    int miscompares = 0;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .be(be2), .rdata(rdata2), .ready(ready2), .err(err2)
    );

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input bit d0, input bit pre_rst, input bit scramble,
                             input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] b, input logic [31:0] exp_rd,
                             input logic exp_err, input string tag);
        exp_t e;
        int   n;
        bit   seen;
        e.rd = exp_rd;
        e.er = exp_err;
        sb.push_back(e);
        @(negedge clk);
        if (pre_rst) rst = 1'b1;
        if (d0) begin
            req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = wd; be0 = b;
        end else begin
            req2 = 1'b1; we2 = wr; addr2 = a; wdata2 = wd; be2 = b;
        end
        if (pre_rst) begin
            @(negedge clk);
            rst = 1'b0;
        end
        @(posedge clk);
        if (scramble) begin
            #1;
            req2 = 1'b0; we2 = ~wr; addr2 = 32'h0; wdata2 = 32'hFFFF_FFFF; be2 = 4'hF;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = d0 ? ready0 : ready2;
        end
        req0 = 1'b0;
        req2 = 1'b0;
        check({tag, " latency"}, 32'(n), d0 ? 32'd1 : 32'd3);
        e = sb.pop_front();
        check({tag, " rdata"}, d0 ? rdata0 : rdata2, e.rd);
        check({tag, " err"}, {31'b0, d0 ? err0 : err2}, {31'b0, e.er});
        @(negedge clk);
        check({tag, " one-shot"}, {31'b0, d0 ? ready0 : ready2}, 32'd0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] cur;

        req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0; be2 = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;

        #1;
        check("reset ready", {31'b0, ready2}, 32'd0);
        check("reset err",   {31'b0, err2},   32'd0);
        check("reset rdata", rdata2,          32'd0);
        check("reset ready0", {31'b0, ready0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_access(0, 0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, "store full");
        do_access(0, 0, 0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, "load full");
        do_access(0, 0, 0, 1, 32'h10, 32'h0000_1234, 4'b0011, 32'h0, 0, "store partial");
        do_access(0, 0, 0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_1234, 0, "load partial");

        do_access(0, 0, 0, 1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 0, "store word0");
        do_access(0, 0, 0, 0, 32'h13, 32'h0, 4'h0, 32'h0, 1, "load misaligned");
        do_access(0, 0, 0, 0, 32'h400, 32'h0, 4'h0, 32'h0, 1, "load out of range");
        do_access(0, 0, 0, 1, 32'h400, 32'h1234_5678, 4'hF, 32'h0, 1, "store out of range");
        do_access(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 0, "word0 untouched");

        do_access(0, 0, 0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, "store be0");
        do_access(0, 0, 0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_1234, 0, "load after be0");

        do_access(0, 0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_1234, 0, "scrambled load");
        do_access(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 0, "after scramble");

        do_access(0, 0, 0, 1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 0, "store 0x20");
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h55AA_55AA; be2 = 4'hF;
        @(posedge clk);
        #1 req2 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort ready", {31'b0, ready2}, 32'd0);
        check("abort rdata", rdata2, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort no ready", {31'b0, ready2}, 32'd0);
        end
        do_access(0, 0, 0, 0, 32'h20, 32'h0, 4'h0, 32'h1122_3344, 0, "load after abort");

        do_access(0, 1, 0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_1234, 0, "req across reset");

        do_access(1, 0, 0, 1, 32'h4, 32'hA5A5_0004, 4'hF, 32'h0, 0, "w0 store 4");
        do_access(1, 0, 0, 1, 32'h8, 32'h5A5A_0008, 4'hF, 32'h0, 0, "w0 store 8");

        cur  = 32'h4;
        e.rd = 32'hA5A5_0004;
        e.er = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = cur;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("held ready", {31'b0, ready0}, 32'(k % 2));
            if (ready0) begin
                e = sb.pop_front();
                check("held rdata", rdata0, e.rd);
                cur   = (cur == 32'h4) ? 32'h8 : 32'h4;
                addr0 = cur;
                e.rd  = (cur == 32'h4) ? 32'hA5A5_0004 : 32'h5A5A_0008;
                sb.push_back(e);
            end
        end
        req0 = 1'b0;
        sb.delete();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
